mc_control_fsm: RTL

Multicycle RISC-V (RV32I subset) control unit for the Lab 4 datapath. It is a Moore main FSM plus combinational ALU and immediate decoders. It sits directly upstream of the datapath's 3:1 select muxes and drives their 2-bit selects: resultsrc, alusrca and alusrcb. It also drives the write enables for PC, IR, memory and the register file.

---
 rtl/mc_control_fsm.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control unit: Moore main FSM plus ALU and immediate decoders.
// Optional perf counters (cycle_cnt, instret_cnt) are built when MC_PERF_CNT_EN is defined.
module mc_control_fsm #(
  parameter int ALUCTL_W = 3,
  parameter int IMMSRC_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                zero,
  output logic                pcwrite,
  output logic                adrsrc,
  output logic                memwrite,
  output logic                irwrite,
  output logic                regwrite,
  output logic [1:0]          resultsrc,
  output logic [1:0]          alusrca,
  output logic [1:0]          alusrcb,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic [IMMSRC_W-1:0] immsrc
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instret_cnt
`endif
);

  // state    | meaning
  // FETCH    | read instr at PC into IR, PC <= PC+4
  // DECODE   | read regs, precompute OldPC+imm target
  // MEMADR   | address = rs1 + imm for lw/sw
  // MEMREAD  | read data memory at ALUOut
  // MEMWB    | write loaded data to rd
  // MEMWRITE | store rs2 at ALUOut
  // EXECUTER | ALU on rs1, rs2
  // EXECUTEI | ALU on rs1, imm
  // ALUWB    | write ALUOut to rd
  // JAL      | PC <= target, ALU forms OldPC+4 for link
  // BEQ      | compare rs1, rs2; PC <= target when equal
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t      state, state_nxt, st_out;
  logic        pcupdate, branch;
  logic        irwrite_s, memwrite_s, regwrite_s;
  logic [1:0]  aluop;
  logic [2:0]  alu_dec;
  logic [1:0]  imm_dec;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:    state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_R:         state_nxt = EXECUTER;
          OP_I:         state_nxt = EXECUTEI;
          OP_JAL:       state_nxt = JAL;
          OP_BEQ:       state_nxt = BEQ;
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR:   state_nxt = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_nxt = MEMWB;
      EXECUTER: state_nxt = ALUWB;
      EXECUTEI: state_nxt = ALUWB;
      JAL:      state_nxt = ALUWB;
      default:  state_nxt = FETCH;
    endcase
  end

  // During reset the outputs look like FETCH, but with all write enables held off.
  always_comb begin
    st_out     = reset ? FETCH : state;
    irwrite_s  = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    adrsrc     = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    case (st_out)
      FETCH: begin
        irwrite_s = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        pcupdate  = 1'b1;
      end
      DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      MEMREAD:  adrsrc = 1'b1;
      MEMWB: begin
        resultsrc  = 2'b01;
        regwrite_s = 1'b1;
      end
      MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite_s = 1'b1;
      end
      EXECUTER: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
      end
      EXECUTEI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
      end
      ALUWB:    regwrite_s = 1'b1;
      JAL: begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      BEQ: begin
        alusrca = 2'b10;
        aluop   = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcwrite  = ~reset & (pcupdate | (branch & zero));
  assign irwrite  = ~reset & irwrite_s;
  assign memwrite = ~reset & memwrite_s;
  assign regwrite = ~reset & regwrite_s;

  always_comb begin
    alu_dec = ALU_ADD;
    case (aluop)
      2'b01: alu_dec = ALU_SUB;
      2'b10: begin
        case (funct3)
          3'b000:  alu_dec = (op[5] & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_dec = ALU_SLT;
          3'b110:  alu_dec = ALU_OR;
          3'b111:  alu_dec = ALU_AND;
          default: alu_dec = ALU_ADD;
        endcase
      end
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    imm_dec = 2'b00;
    case (op)
      OP_SW:   imm_dec = 2'b01;
      OP_BEQ:  imm_dec = 2'b10;
      OP_JAL:  imm_dec = 2'b11;
      default: imm_dec = 2'b00;
    endcase
  end

  assign alucontrol = ALUCTL_W'(alu_dec);
  assign immsrc     = IMMSRC_W'(imm_dec);

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if ((state != FETCH) && (state_nxt == FETCH))
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule
